// File: rtl/cond_logic.sv
// rtl/cond_logic.sv - condition evaluation, side-effect gating and stored NZCV flag register
module cond_logic #(
    parameter int FLAG_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [FLAG_W-1:0] flags_i,
    input  logic [3:0]        cond,
    input  logic [1:0]        flagw,
    input  logic              pcs,
    input  logic              regw,
    input  logic              memw,
    input  logic              nowrite,
    output logic              pcsrc,
    output logic              regwrite,
    output logic              memwrite,
    output logic              condex,
    output logic [FLAG_W-1:0] flags_q
);

    localparam int N_IDX = FLAG_W - 1;
    localparam int Z_IDX = FLAG_W - 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    logic              flag_n;
    logic              flag_z;
    logic              flag_c;
    logic              flag_v;
    logic [FLAG_W-1:0] flags_d;

    // Condition is judged on the stored flags only, never on this instruction's ALU result.
    assign flag_n = flags_q[N_IDX];
    assign flag_z = flags_q[Z_IDX];
    assign flag_c = flags_q[C_IDX];
    assign flag_v = flags_q[V_IDX];

    always_comb begin
        condex = 1'b0;
        case (cond)
            4'b0000: condex = flag_z;
            4'b0001: condex = ~flag_z;
            4'b0010: condex = flag_c;
            4'b0011: condex = ~flag_c;
            4'b0100: condex = flag_n;
            4'b0101: condex = ~flag_n;
            4'b0110: condex = flag_v;
            4'b0111: condex = ~flag_v;
            4'b1000: condex = flag_c & ~flag_z;
            4'b1001: condex = ~flag_c | flag_z;
            4'b1010: condex = (flag_n == flag_v);
            4'b1011: condex = (flag_n != flag_v);
            4'b1100: condex = ~flag_z & (flag_n == flag_v);
            4'b1101: condex = flag_z | (flag_n != flag_v);
            4'b1110: condex = 1'b1;
            default: condex = 1'b0;
        endcase
    end

    assign pcsrc    = pcs & condex;
    assign memwrite = memw & condex;
    assign regwrite = regw & condex & ~nowrite;

    // N,Z and C,V are written independently so logical ops can preserve carry/overflow.
    always_comb begin
        flags_d = flags_q;
        if (en && condex) begin
            if (flagw[1]) begin
                flags_d[N_IDX:Z_IDX] = flags_i[N_IDX:Z_IDX];
            end
            if (flagw[0]) begin
                flags_d[C_IDX:V_IDX] = flags_i[C_IDX:V_IDX];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

endmodule
